// File: rtl/imem_block_responder.sv
// imem_block_responder: instruction-cache block-read responder with a loadable word store.
// A block read returns four consecutive words after a fixed latency.
module imem_block_responder #(
  parameter int LATENCY     = 4,
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           read,
  input  logic [27:0]    address,
  output logic [127:0]   readdata,
  output logic           busywait,
  input  logic           load_en,
  input  logic [AW-1:0]  load_addr,
  input  logic [31:0]    load_data,
  output logic [15:0]    resp_count
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  logic [1:0]    r_state;
  logic [7:0]    r_cnt;
  logic [AW-3:0] r_addr;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          w_unused_addr;
  assign w_unused_addr = ^address[27:AW-2];
  // Combinational so the cache sees busy in the very cycle read rises.
  assign busywait = !reset && (r_state == S_IDLE ? read : r_state == S_WAIT);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_addr     <= '0;
      readdata   <= '0;
      resp_count <= '0;
    end else if (r_state == S_IDLE) begin
      if (read) begin
        r_state <= S_WAIT;
        r_cnt   <= 8'(LATENCY - 1);
        r_addr  <= address[AW-3:0];
      end
    end else if (r_state == S_WAIT) begin
      if (!read) begin
        r_state <= S_IDLE;
      end else if (r_cnt == '0) begin
        r_state    <= S_RESP;
        readdata   <= {r_mem[{r_addr, 2'b11}], r_mem[{r_addr, 2'b10}],
                       r_mem[{r_addr, 2'b01}], r_mem[{r_addr, 2'b00}]};
        resp_count <= resp_count + 16'd1;
      end else begin
        r_cnt <= r_cnt - 8'd1;
      end
    end else begin
      r_state <= S_IDLE;
    end
  end
  // Store is never reset; a same-edge load is seen only by later fetches.
  always_ff @(posedge clock)
    if (load_en) r_mem[load_addr] <= load_data;
endmodule
